ram_responder: RTL and testbench
================================

Name: ram_responder

Overview:
- Memory-side endpoint of the CPU–RAM request interface, i.e. the responder that answers memaddr/memstore/memREN/memWEN with ramload/ramstate.
- Holds a word-addressed storage array, inserts a programmable wait-state latency and flags illegal requests.
- Used as the RAM behind the top-level CPU block in simulation and as the on-chip RAM in synthesis builds.

Parameters:
- LAT, 2, wait cycles inserted before ACCESS (0..15)
- DEPTH, 1024, number of 32-bit words (power of two)
- CNT_W, 16, width of the access statistic counters

Ports:
- CLK  in  1  system clock
- nRST  in  1  reset; asynchronous, active-high
- memaddr  in  32  byte address of request
- memstore  in  32  write data
- memREN  in  1  read request, level, held until ACCESS/ERROR seen
- memWEN  in  1  write request, level, held until ACCESS/ERROR seen
- ramload  out  32  read data, valid while ramstate==ACCESS for a read
- ramstate  out  2  FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11
- rd_count  out  CNT_W  completed reads, wraps
- wr_count  out  CNT_W  completed writes, wraps

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock port CLK, reset port nRST.
- Reset: FSM=IDLE, ramload=0, rd_count=0, wr_count=0, wait counter=0; ramstate reads FREE when no request is present. Array contents are not reset. Reset asserted mid-transaction aborts it; a pending write is not committed.
- req = memREN | memWEN.
- illegal =
  - memREN & memWEN, or
  - memaddr[1:0] != 0, or
  - word index memaddr[31:2] >= DEPTH.
- FSM states IDLE, WAIT, ACCESS. ramstate is combinational from state and inputs:
  - IDLE, no req: ramstate=FREE.
  - IDLE, req & illegal: ramstate=ERROR. Stay in IDLE; no array access, no counter change.
  - IDLE, req & legal: ramstate=BUSY. Latch addr/op/data. If LAT==0, go to ACCESS; otherwise load wcnt=LAT-1 and go to WAIT.
  - WAIT: ramstate=BUSY.
    - If wcnt==0, go to ACCESS; else decrement wcnt.
    - Abort to IDLE (no write, ramstate FREE/BUSY per IDLE rules next cycle) if req drops, or if memaddr/op differ from latched values.
  - ACCESS: ramstate=ACCESS for exactly one cycle.
    - Read: ramload = array[latched index], registered on entry to ACCESS and held until the next read ACCESS.
    - Write: array[latched index] <= latched memstore at the edge leaving ACCESS.
    - The matching counter increments at that same edge.
    - Always return to IDLE. A request still held restarts a full BUSY sequence.
- Latency: a legal request first presented at cycle t and held shows BUSY during cycles t..t+LAT and ACCESS at t+LAT+1.
- Write data: memstore is sampled at acceptance only; later changes are ignored.
- Read-after-write to the same address returns the new data; the write commits before the next ACCESS can occur.
- Counters wrap from 2^CNT_W-1 to 0.

Test Plan:
- Reset with LAT=2, no req -> ramstate=FREE, ramload=0, counters 0. Assert nRST mid-WAIT -> FSM IDLE immediately, no write committed.
- Write 0xDEADBEEF to 0x40, then read 0x40 -> each shows BUSY 3 cycles, then ACCESS 1 cycle. Read ramload=0xDEADBEEF, wr_count=1, rd_count=1.
- LAT=0: read 0x0 held -> BUSY cycle t, ACCESS cycle t+1.
- memREN=memWEN=1 at 0x10 -> ERROR. Misaligned 0x42 -> ERROR. Address 4*DEPTH -> ERROR. Counters and array unchanged.
- Write to 0x80, then drop memWEN during WAIT -> abort to IDLE. A later read of 0x80 returns the prior contents, wr_count unchanged.
- Back-to-back reads 0x0 then 0x4 with addr changed the cycle after ACCESS -> second sequence BUSY LAT+1 cycles then ACCESS. Preload CNT_W=4 via 16 reads -> rd_count wraps to 0.

Source files
------------

// File: rtl/ram_responder.sv
// ram_responder
//   Memory-side endpoint of the CPU-RAM request interface. Holds a
//   word-addressed array and answers level requests. A programmable number
//   of wait states is inserted before the single ACCESS cycle. Requests with
//   both enables set, a misaligned address or an out-of-range address are
//   flagged as ERROR.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no transaction owned; ramstate decoded from live request
//   WAIT   | request latched, counting down wait states (BUSY)
//   ACCESS | one-cycle data phase; write/counter commit at exit edge
//
// Ports
//   CLK        system clock
//   nRST       asynchronous reset, active-high despite the name
//   memaddr    byte address of request
//   memstore   write data, sampled at acceptance only
//   memREN     read request (level)
//   memWEN     write request (level)
//   ramload    read data, updated on entry to a read ACCESS
//   ramstate   FREE=00 BUSY=01 ACCESS=10 ERROR=11
//   rd_count   completed reads, wraps
//   wr_count   completed writes, wraps
module ram_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      memaddr,
    input  logic [31:0]      memstore,
    input  logic             memREN,
    input  logic             memWEN,
    output logic [31:0]      ramload,
    output logic [1:0]       ramstate,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] WLOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    localparam logic [1:0] RS_FREE   = 2'b00;
    localparam logic [1:0] RS_BUSY   = 2'b01;
    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, next_state;

    logic [3:0]       wcnt;
    logic [31:0]      laddr;
    logic [31:0]      ldata;
    logic             lwr;
    logic [31:0]      mem [DEPTH];

    logic             req;
    logic             illegal;
    logic             same_req;
    logic             accept;
    logic             load_rd;
    logic [IDX_W-1:0] rd_idx;

    assign req = memREN | memWEN;

    // Any address bit above the word index makes the index >= DEPTH.
    assign illegal = (memREN & memWEN) | (memaddr[1:0] != 2'b00)
                   | (|memaddr[31:IDX_W+2]);

    // The master must keep presenting exactly what was accepted while we wait.
    assign same_req = req & (memaddr == laddr) & (memWEN == lwr) & (memREN == ~lwr);

    always_comb begin
        next_state = state;
        ramstate   = RS_FREE;
        accept     = 1'b0;
        load_rd    = 1'b0;
        rd_idx     = laddr[IDX_W+1:2];
        case (state)
            IDLE: begin
                if (req) begin
                    if (illegal) begin
                        ramstate = RS_ERROR;
                    end else begin
                        ramstate = RS_BUSY;
                        accept   = 1'b1;
                        if (LAT == 0) begin
                            // Nothing latched yet, so read straight from the bus.
                            next_state = ACCESS;
                            load_rd    = memREN;
                            rd_idx     = memaddr[IDX_W+1:2];
                        end else begin
                            next_state = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                ramstate = RS_BUSY;
                if (!same_req) begin
                    next_state = IDLE;
                end else if (wcnt == 4'd0) begin
                    next_state = ACCESS;
                    load_rd    = ~lwr;
                end
            end
            ACCESS: begin
                ramstate   = RS_ACCESS;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state    <= IDLE;
            wcnt     <= 4'd0;
            laddr    <= 32'd0;
            ldata    <= 32'd0;
            lwr      <= 1'b0;
            ramload  <= 32'd0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                laddr <= memaddr;
                ldata <= memstore;
                lwr   <= memWEN;
                wcnt  <= WLOAD;
            end else if (state == WAIT && wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end
            if (load_rd) begin
                ramload <= mem[rd_idx];
            end
            if (state == ACCESS) begin
                if (lwr) begin
                    wr_count <= wr_count + 1'b1;
                end else begin
                    rd_count <= rd_count + 1'b1;
                end
            end
        end
    end

    // Array has no reset; the nRST term keeps a reset during ACCESS from committing.
    always_ff @(posedge CLK) begin
        if (!nRST && state == ACCESS && lwr) begin
            mem[laddr[IDX_W+1:2]] <= ldata;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder
//   Directed bench for ram_responder: one instance with LAT=2 and one with
//   LAT=0, both with 4-bit counters so wrap-around is reachable.
module tb_ram_responder;

    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] ACCESS = 2'b10;
    localparam logic [1:0] ERROR  = 2'b11;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] memaddr, memstore;
    logic        memREN, memWEN;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic [3:0]  rd_count, wr_count;

    logic [31:0] addr0, store0;
    logic        ren0, wen0;
    logic [31:0] ramload0;
    logic [1:0]  ramstate0;
    logic [3:0]  rd_count0, wr_count0;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_rd = 4'd0;
    logic [3:0] exp_wr = 4'd0;

    always #5 CLK = ~CLK;

    ram_responder #(.LAT(2), .DEPTH(1024), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .memaddr(memaddr), .memstore(memstore),
        .memREN(memREN), .memWEN(memWEN), .ramload(ramload),
        .ramstate(ramstate), .rd_count(rd_count), .wr_count(wr_count)
    );

    ram_responder #(.LAT(0), .DEPTH(1024), .CNT_W(4)) dut0 (
        .CLK(CLK), .nRST(nRST), .memaddr(addr0), .memstore(store0),
        .memREN(ren0), .memWEN(wen0), .ramload(ramload0),
        .ramstate(ramstate0), .rd_count(rd_count0), .wr_count(wr_count0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Starts at posedge+1. Returns BUSY count and ramload seen in ACCESS,
    // ending at posedge+1 after the ACCESS cycle with the request still driven.
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          output int busy, output logic [31:0] rdata);
        logic got;
        got      = 1'b0;
        busy     = 0;
        rdata    = 32'd0;
        memREN   = ~wr;
        memWEN   = wr;
        memaddr  = addr;
        memstore = data;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLK);
            if (ramstate == BUSY) busy++;
            if (ramstate == ACCESS) begin
                got   = 1'b1;
                rdata = ramload;
            end
            next_cycle();
            memstore = ~data;
        end
        if (!got) check("access_timeout", 32'd0, 32'd1);
        if (wr) exp_wr++; else exp_rd++;
    endtask

    task automatic idle_check(input string tag);
        memREN = 1'b0;
        memWEN = 1'b0;
        @(negedge CLK);
        check({tag, "_state"}, 32'(ramstate), 32'(FREE));
        check({tag, "_wr"}, 32'(wr_count), 32'(exp_wr));
        check({tag, "_rd"}, 32'(rd_count), 32'(exp_rd));
        next_cycle();
    endtask

    initial begin
        int busy;
        logic [31:0] rdata;

        nRST = 1'b1;
        memaddr = 32'd0; memstore = 32'd0; memREN = 1'b0; memWEN = 1'b0;
        addr0 = 32'd0; store0 = 32'd0; ren0 = 1'b0; wen0 = 1'b0;

        repeat (2) next_cycle();
        @(negedge CLK);
        check("rst_state", 32'(ramstate), 32'(FREE));
        check("rst_ramload", ramload, 32'd0);
        check("rst_rd", 32'(rd_count), 32'd0);
        check("rst_wr", 32'(wr_count), 32'd0);
        next_cycle();
        nRST = 1'b0;
        next_cycle();

        // Reset during WAIT must abort the pending write.
        do_req(1'b1, 32'h100, 32'h1111_1111, busy, rdata);
        idle_check("w100");
        memWEN = 1'b1; memaddr = 32'h100; memstore = 32'h2222_2222;
        @(negedge CLK);
        check("rstw_busy0", 32'(ramstate), 32'(BUSY));
        next_cycle();
        nRST = 1'b1;
        @(negedge CLK);
        check("rstw_rd0", 32'(rd_count), 32'd0);
        check("rstw_wr0", 32'(wr_count), 32'd0);
        next_cycle();
        next_cycle();
        @(negedge CLK);
        check("rstw_no_access", 32'(ramstate), 32'(BUSY));
        next_cycle();
        nRST = 1'b0;
        memWEN = 1'b0;
        exp_rd = 4'd0;
        exp_wr = 4'd0;
        @(negedge CLK);
        check("rstw_free", 32'(ramstate), 32'(FREE));
        next_cycle();
        do_req(1'b0, 32'h100, 32'd0, busy, rdata);
        check("rstw_data", rdata, 32'h1111_1111);
        idle_check("rstw_after");

        // Write then read 0x40, memstore scrambled after acceptance.
        do_req(1'b1, 32'h40, 32'hDEAD_BEEF, busy, rdata);
        check("w40_busy", 32'(busy), 32'd3);
        idle_check("w40");
        do_req(1'b0, 32'h40, 32'd0, busy, rdata);
        check("r40_busy", 32'(busy), 32'd3);
        check("r40_data", rdata, 32'hDEAD_BEEF);
        check("r40_ramload_held", ramload, 32'hDEAD_BEEF);
        idle_check("r40");

        // Illegal requests.
        memREN = 1'b1; memWEN = 1'b1; memaddr = 32'h10;
        @(negedge CLK);
        check("err_both", 32'(ramstate), 32'(ERROR));
        next_cycle();
        @(negedge CLK);
        check("err_both_hold", 32'(ramstate), 32'(ERROR));
        next_cycle();
        memREN = 1'b0; memaddr = 32'h42; memstore = 32'h5A5A_5A5A;
        @(negedge CLK);
        check("err_misalign", 32'(ramstate), 32'(ERROR));
        next_cycle();
        memWEN = 1'b0; memREN = 1'b1; memaddr = 32'd4096;
        @(negedge CLK);
        check("err_range", 32'(ramstate), 32'(ERROR));
        next_cycle();
        memaddr = 32'd4092;
        @(negedge CLK);
        check("last_word_ok", 32'(ramstate), 32'(BUSY));
        memREN = 1'b0;
        next_cycle();
        idle_check("err");
        do_req(1'b0, 32'h40, 32'd0, busy, rdata);
        check("err_data", rdata, 32'hDEAD_BEEF);
        idle_check("err_after");

        // Write abort by dropping memWEN during WAIT.
        do_req(1'b1, 32'h80, 32'hAAAA_5555, busy, rdata);
        idle_check("w80");
        memWEN = 1'b1; memaddr = 32'h80; memstore = 32'h5555_AAAA;
        next_cycle();
        memWEN = 1'b0;
        @(negedge CLK);
        check("abort_busy", 32'(ramstate), 32'(BUSY));
        next_cycle();
        @(negedge CLK);
        check("abort_free", 32'(ramstate), 32'(FREE));
        next_cycle();
        do_req(1'b0, 32'h80, 32'd0, busy, rdata);
        check("abort_data", rdata, 32'hAAAA_5555);
        idle_check("abort");

        // Back-to-back reads, address changed right after ACCESS.
        do_req(1'b1, 32'h0, 32'h0BAD_F00D, busy, rdata);
        idle_check("w0");
        do_req(1'b1, 32'h4, 32'h0000_0004, busy, rdata);
        idle_check("w4");
        do_req(1'b0, 32'h0, 32'd0, busy, rdata);
        check("b2b_r0", rdata, 32'h0BAD_F00D);
        do_req(1'b0, 32'h4, 32'd0, busy, rdata);
        check("b2b_busy", 32'(busy), 32'd3);
        check("b2b_r4", rdata, 32'h0000_0004);
        idle_check("b2b");

        // Counter wrap with 4-bit counters.
        nRST = 1'b1;
        next_cycle();
        nRST = 1'b0;
        exp_rd = 4'd0;
        exp_wr = 4'd0;
        for (int i = 0; i < 15; i++) begin
            do_req(1'b0, 32'h0, 32'd0, busy, rdata);
            idle_check("wrap_step");
        end
        check("wrap_15", 32'(rd_count), 32'd15);
        do_req(1'b0, 32'h0, 32'd0, busy, rdata);
        idle_check("wrap_step");
        check("wrap_0", 32'(rd_count), 32'd0);

        // LAT=0 instance: BUSY at t, ACCESS at t+1.
        wen0 = 1'b1; addr0 = 32'h0; store0 = 32'h0000_0077;
        @(negedge CLK);
        check("l0_w_busy", 32'(ramstate0), 32'(BUSY));
        next_cycle();
        store0 = 32'hFFFF_FFFF;
        @(negedge CLK);
        check("l0_w_access", 32'(ramstate0), 32'(ACCESS));
        next_cycle();
        wen0 = 1'b0;
        ren0 = 1'b1;
        @(negedge CLK);
        check("l0_r_busy", 32'(ramstate0), 32'(BUSY));
        next_cycle();
        @(negedge CLK);
        check("l0_r_access", 32'(ramstate0), 32'(ACCESS));
        check("l0_r_data", ramload0, 32'h0000_0077);
        next_cycle();
        ren0 = 1'b0;
        @(negedge CLK);
        check("l0_free", 32'(ramstate0), 32'(FREE));
        check("l0_rd", 32'(rd_count0), 32'd1);
        check("l0_wr", 32'(wr_count0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
